// File: rtl/mmio_fifo_csr.sv
// MMIO-mapped FIFO register bank: DATA push/pop, STATUS, CTRL (flush / clear flags).
// Optional head-peek register at BASE+6 enabled by defining MMIO_FIFO_PEEK_EN.
module mmio_fifo_csr #(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020,
  parameter int          AF_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mmio_wr_valid,
  input  logic [15:0]              mmio_wr_addr,
  input  logic [63:0]              mmio_wr_data,
  input  logic                     mmio_rd_valid,
  input  logic [15:0]              mmio_rd_addr,
  input  logic [8:0]               mmio_rd_tid,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [8:0]               rsp_tid,
  output logic [63:0]              rsp_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] A_DATA = BASE_ADDR;
  localparam logic [15:0] A_STAT = BASE_ADDR + 16'd2;
  localparam logic [15:0] A_CTRL = BASE_ADDR + 16'd4;
`ifdef MMIO_FIFO_PEEK_EN
  localparam logic [15:0] A_PEEK = BASE_ADDR + 16'd6;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              overflow, underflow;

  logic push_req, pop_req, ctrl_wr, flush, clr;
  logic push_ok, pop_ok, ovf_evt, unf_evt;
  logic [CW-1:0] count_nxt;

  assign push_req = mmio_wr_valid && (mmio_wr_addr == A_DATA);
  assign ctrl_wr  = mmio_wr_valid && (mmio_wr_addr == A_CTRL);
  assign flush    = ctrl_wr && mmio_wr_data[0];
  assign clr      = ctrl_wr && mmio_wr_data[1];
  assign pop_req  = mmio_rd_valid && (mmio_rd_addr == A_DATA);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop_ok   = pop_req && !empty;
  assign unf_evt  = pop_req && empty;
  assign push_ok  = push_req && !flush && (!full || pop_ok);
  assign ovf_evt  = push_req && !flush && full && !pop_ok;
  assign count_nxt = flush ? '0 : count + CW'(push_ok) - CW'(pop_ok);

  logic [63:0] head, status, rd_data;
  logic        rd_hit;

  always_comb begin
    head = '0;
    head[DATA_W-1:0] = mem[rd_ptr];
    status = '0;
    status[0] = empty;
    status[1] = full;
    status[2] = overflow;
    status[3] = underflow;
    status[4] = almost_full;
    status[16 +: CW] = count;
    rd_hit  = 1'b1;
    rd_data = '0;
    case (mmio_rd_addr)
      A_DATA:  rd_data = empty ? '0 : head;
      A_STAT:  rd_data = status;
      A_CTRL:  rd_data = '0;
`ifdef MMIO_FIFO_PEEK_EN
      A_PEEK:  rd_data = empty ? '0 : head;
`endif
      default: rd_hit = 1'b0;
    endcase
  end

  // Storage is intentionally not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= mmio_wr_data[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_tid     <= '0;
      rsp_data    <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CW'(DEPTH));
      almost_full <= (count_nxt >= CW'(AF_THRESH));
      // New events take priority over a same-cycle clear.
      overflow    <= ovf_evt | (overflow  & ~clr);
      underflow   <= unf_evt | (underflow & ~clr);
      rsp_valid   <= mmio_rd_valid;
      rsp_hit     <= mmio_rd_valid && rd_hit;
      rsp_data    <= mmio_rd_valid ? rd_data : '0;
      if (mmio_rd_valid) rsp_tid <= mmio_rd_tid;
    end
  end
endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Self-checking bench for mmio_fifo_csr: directed test-plan steps plus random traffic
// against a queue-based reference model.
module tb_mmio_fifo_csr;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'h0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic [15:0] mmio_wr_addr = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_rd_addr = '0;
  logic [8:0]  mmio_rd_tid = '0;
  logic        rsp_valid, rsp_hit;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [3:0]  count;
  logic        full, empty, almost_full;

  mmio_fifo_csr #(.DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_tid(mmio_rd_tid),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] q[$];
  bit          ovf = 0, unf = 0;
  logic [63:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] status_m();
    logic [63:0] s;
    int n;
    n = q.size();
    s = '0;
    s[0] = (n == 0);
    s[1] = (n == DEPTH);
    s[2] = ovf;
    s[3] = unf;
    s[4] = (n >= DEPTH - 2);
    s[31:16] = 16'(n);
    return s;
  endfunction

  // One bus cycle: model computes the response from pre-state, then applies the cycle's effects.
  task automatic cyc(input bit wv, input logic [15:0] wa, input logic [63:0] wd,
                     input bit rv, input logic [15:0] ra);
    logic [8:0]  tid;
    bit          ehit;
    logic [63:0] edata;
    int          n;
    bit          popping;
    tid = 9'($urandom);
    mmio_wr_valid = wv; mmio_wr_addr = wa; mmio_wr_data = wd;
    mmio_rd_valid = rv; mmio_rd_addr = ra; mmio_rd_tid = tid;
    ehit = 1; edata = '0;
    if (ra == BASE) begin
      if (q.size() > 0) edata = q[0];
    end else if (ra == BASE + 16'd2) edata = status_m();
    else if (ra == BASE + 16'd4) edata = '0;
`ifdef MMIO_FIFO_PEEK_EN
    else if (ra == BASE + 16'd6) begin
      if (q.size() > 0) edata = q[0];
    end
`endif
    else ehit = 0;
    n = q.size();
    popping = rv && (ra == BASE);
    if (wv && wa == BASE + 16'd4 && wd[1]) begin ovf = 0; unf = 0; end
    if (popping) begin
      if (n > 0) void'(q.pop_front());
      else unf = 1;
    end
    if (wv && wa == BASE) begin
      if (n < DEPTH || (popping && n > 0)) q.push_back(wd);
      else ovf = 1;
    end
    if (wv && wa == BASE + 16'd4 && wd[0]) q.delete();
    @(posedge clk); #1;
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'(rv));
    if (rv) begin
      chk("rsp_hit", 64'(rsp_hit), 64'(ehit));
      chk("rsp_tid", 64'(rsp_tid), 64'(tid));
      chk("rsp_data", rsp_data, edata);
      last_data = rsp_data;
    end
    chk("count", 64'(count), 64'(q.size()));
    chk("flags", 64'({full, empty, almost_full}),
        64'({q.size() == DEPTH, q.size() == 0, q.size() >= DEPTH - 2}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete(); ovf = 0; unf = 0;
    chk("rst_rsp", 64'({rsp_valid, rsp_hit}), 64'(0));
    chk("rst_tid", 64'(rsp_tid), 64'(0));
    chk("rst_data", rsp_data, 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_flags", 64'({full, empty, almost_full}), 64'(3'b010));
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return BASE;
      5: return BASE + 16'd2;
      6: return BASE + 16'd4;
      7: return BASE + 16'd6;
      8: return BASE + 16'd1;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] wa, ra;
    logic [63:0] wd;
    @(posedge clk); #1;
    do_reset();
    cyc(0, 0, 0, 1, BASE + 16'd2);
    chk("status_after_reset", last_data, 64'h1);

    for (int i = 1; i <= 8; i++) cyc(1, BASE, 64'(i * 'h11), 0, 0);
    cyc(1, BASE, 64'h99, 0, 0);
    cyc(0, 0, 0, 1, BASE + 16'd2);
    chk("status_full_ovf", last_data, 64'h0008_0016);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 1, BASE);
      chk("drain_order", last_data, 64'(i * 'h11));
    end
    cyc(0, 0, 0, 1, BASE);
    chk("pop_empty", last_data, 64'h0);
    cyc(0, 0, 0, 1, BASE + 16'd2);
    chk("status_unf", last_data, 64'hD);
    cyc(1, BASE + 16'd4, 64'h2, 1, BASE + 16'd2);
    cyc(0, 0, 0, 1, BASE + 16'd2);
    chk("status_cleared", last_data, 64'h1);

    for (int i = 1; i <= 8; i++) cyc(1, BASE, 64'(i), 0, 0);
    cyc(1, BASE, 64'hAA, 1, BASE);
    chk("full_push_pop", last_data, 64'h1);
    chk("full_push_pop_cnt", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, BASE);
    chk("aa_eighth", last_data, 64'hAA);

    // Empty push+pop: pop returns 0 with underflow, push still lands.
    cyc(1, BASE, 64'h77, 1, BASE);
    chk("empty_push_pop", last_data, 64'h0);
    cyc(1, BASE + 16'd4, 64'h3, 0, 0);

    for (int i = 0; i < 3; i++) cyc(1, BASE, 64'($urandom), 0, 0);
    cyc(1, BASE, 64'hCC, 1, BASE + 16'd2);
    cyc(1, BASE + 16'd4, 64'h1, 1, BASE);
    cyc(1, BASE + 16'd4, 64'h1, 0, 0);
    cyc(0, 0, 0, 1, BASE);
    chk("flush_empty", last_data, 64'h0);
    cyc(1, BASE + 16'd4, 64'h2, 0, 0);

    cyc(1, BASE, 64'h5A, 0, 0);
    cyc(0, 0, 0, 1, BASE + 16'd6);
    cyc(0, 0, 0, 1, BASE + 16'd6);
`ifdef MMIO_FIFO_PEEK_EN
    chk("peek", last_data, 64'h5A);
`else
    chk("peek_unmapped", last_data, 64'h0);
`endif
    cyc(0, 0, 0, 1, BASE + 16'd9);

    for (int i = 0; i < 3; i++) cyc(1, BASE, 64'($urandom), 0, 0);
    do_reset();
    cyc(0, 0, 0, 1, BASE + 16'd2);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      wa = rnd_addr();
      ra = rnd_addr();
      wd = {$urandom, $urandom};
      if (wa == BASE + 16'd4)
        wd = 64'(($urandom_range(0, 9) == 0) ? 1 : 0) | 64'(($urandom_range(0, 3) == 0) ? 2 : 0);
      cyc(bit'($urandom_range(0, 1)), wa, wd, bit'($urandom_range(0, 1)), ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
